uart_xcvr: RTL and testbench



---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_xcvr.sv | 217 +++++++++++++++++++++
 tb/tb_uart_xcvr.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encodings and parity helper for the uart_xcvr
// transceiver and its baud-tick generator.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  // Narrow frames are zero-extended by the caller, so unused upper bits add no ones.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    case (mode)
      PAR_ODD:  return ~^data;
      PAR_EVEN: return ^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every CLK_DIV clocks, restartable
// with a synchronous clear so bit timing can be phase-aligned to an event.
module uart_baud_tick #(
  parameter int CLK_DIV = 68
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = !clr && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver: single system clock, 16x oversampled receive,
// configurable data bits / parity / stop bits, valid-ready byte handshakes.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = 68,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam logic [3:0] OS_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_LAST  = 4'(MID_SAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  // ---------------------------------------------------------------- transmit
  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic [3:0]           tx_os;
  logic [2:0]           tx_bit;
  logic                 tx_stop;
  logic                 tx_tick;
  logic                 tx_bit_end;

  // Counter is held clear while idle, so the first bit starts exactly at accept.
  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tx_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tx_ready),
    .tick (tx_tick)
  );

  assign tx_bit_end = tx_tick && (tx_os == OS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_os    <= 4'd0;
      tx_bit   <= 3'd0;
      tx_stop  <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      if (tx_valid) begin
        tx_shift <= tx_data;
        tx_par   <= parity_bit(8'(tx_data), PARITY);
        tx_os    <= 4'd0;
        tx       <= 1'b0;
        tx_ready <= 1'b0;
        tx_state <= TX_START;
      end
    end else if (tx_tick) begin
      tx_os <= tx_bit_end ? 4'd0 : tx_os + 4'd1;
      if (tx_bit_end) begin
        case (tx_state)
          TX_START: begin
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= 3'd0;
            tx_state <= TX_DATA;
          end
          TX_DATA: begin
            if (tx_bit != BIT_LAST) begin
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 3'd1;
            end else if (PARITY != PAR_NONE) begin
              tx       <= tx_par;
              tx_state <= TX_PARITY;
            end else begin
              tx       <= 1'b1;
              tx_stop  <= 1'b0;
              tx_state <= TX_STOP;
            end
          end
          TX_PARITY: begin
            tx       <= 1'b1;
            tx_stop  <= 1'b0;
            tx_state <= TX_STOP;
          end
          TX_STOP: begin
            if (tx_stop != STOP_LAST) begin
              tx_stop <= tx_stop + 1'b1;
            end else begin
              tx_ready <= 1'b1;
              tx_state <= TX_IDLE;
            end
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // ----------------------------------------------------------------- receive
  logic                 rx_meta;
  logic                 rx_sync;
  rx_state_t            rx_state;
  logic [DATA_BITS-1:0] rx_shift;
  logic [3:0]           rx_os;
  logic [2:0]           rx_bit;
  logic                 rx_perr;
  logic                 rx_clr;
  logic                 rx_tick;
  logic                 rx_sample;

  // NOTE: synchroniser flops reset to 1 (line idle) so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign rx_clr = (rx_state == RX_IDLE);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_rx_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (rx_clr),
    .tick (rx_tick)
  );

  // Start bit is sampled mid-bit; every later sample is one full bit after the last.
  assign rx_sample = rx_tick && (rx_os == ((rx_state == RX_START) ? MID_LAST : OS_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= RX_IDLE;
      rx_shift      <= '0;
      rx_os         <= 4'd0;
      rx_bit        <= 3'd0;
      rx_perr       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (rx_state != RX_IDLE && rx_tick) rx_os <= rx_sample ? 4'd0 : rx_os + 4'd1;

      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_os    <= 4'd0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_sample) begin
            rx_bit   <= 3'd0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bit != BIT_LAST) begin
              rx_bit <= rx_bit + 3'd1;
            end else begin
              rx_perr  <= 1'b0;
              rx_state <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end
          end
        end
        RX_PARITY: begin
          if (rx_sample) begin
            rx_perr  <= rx_sync ^ parity_bit(8'(rx_shift), PARITY);
            rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_sample) begin
            // A pending byte is never overwritten; the new frame is dropped instead.
            if (!rx_valid || rx_ready) begin
              rx_data       <= rx_shift;
              rx_parity_err <= rx_perr;
              rx_frame_err  <= !rx_sync;
              rx_valid      <= 1'b1;
            end else begin
              rx_overrun <= 1'b1;
            end
            rx_state <= rx_sync ? RX_IDLE : RX_WAIT_IDLE;
          end
        end
        RX_WAIT_IDLE: begin
          if (rx_sync) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// Scoreboard bench for uart_xcvr: three instances (8N1, 8E1 loopback, 8O1)
// sharing clk/rst_n, with expected received frames queued per instance.
module tb_uart_xcvr;

  localparam int DIV      = 4;
  localparam int BIT_CLKS = 16 * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8N1 instance, bench-driven rx
  logic [7:0] tx_data_n  = 8'h00;
  logic       tx_valid_n = 1'b0;
  logic       tx_ready_n, tx_n;
  logic       rx_n       = 1'b1;
  logic [7:0] rx_data_n;
  logic       rx_valid_n, fe_n, pe_n, ovr_n;
  logic       rx_ready_n = 1'b1;

  // 8E1 instance, tx looped back to rx
  logic [7:0] tx_data_e  = 8'h00;
  logic       tx_valid_e = 1'b0;
  logic       tx_ready_e, tx_e;
  logic [7:0] rx_data_e;
  logic       rx_valid_e, fe_e, pe_e, ovr_e;
  logic       rx_ready_e = 1'b1;

  // 8O1 instance, bench-driven rx
  logic [7:0] rx_data_o, tx_unused_data_o;
  logic       tx_ready_o, tx_o;
  logic       rx_o       = 1'b1;
  logic       rx_valid_o, fe_o, pe_o, ovr_o;
  logic       rx_ready_o = 1'b1;
  logic       tx_valid_o = 1'b0;
  assign tx_unused_data_o = 8'h00;

  uart_xcvr #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n), .tx(tx_n),
    .rx(rx_n), .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_ready(rx_ready_n),
    .rx_frame_err(fe_n), .rx_parity_err(pe_n), .rx_overrun(ovr_n)
  );

  uart_xcvr #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e), .tx(tx_e),
    .rx(tx_e), .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_ready(rx_ready_e),
    .rx_frame_err(fe_e), .rx_parity_err(pe_e), .rx_overrun(ovr_e)
  );

  uart_xcvr #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_o (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_unused_data_o), .tx_valid(tx_valid_o), .tx_ready(tx_ready_o), .tx(tx_o),
    .rx(rx_o), .rx_data(rx_data_o), .rx_valid(rx_valid_o), .rx_ready(rx_ready_o),
    .rx_frame_err(fe_o), .rx_parity_err(pe_o), .rx_overrun(ovr_o)
  );

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q_n[$], q_e[$], q_o[$];
  int n_checks = 0, n_fail = 0;
  int rx_cnt_n = 0, rx_cnt_e = 0, rx_cnt_o = 0;
  int push_n = 0, push_e = 0, push_o = 0;
  int ovr_cyc_n = 0, ovr_cyc_e = 0, ovr_cyc_o = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_frame(input string tag, input int have, input exp_t e,
                           input logic [7:0] d, input logic fe, input logic pe);
    check({tag, "_frame_expected"}, 32'(have > 0), 32'd1);
    if (have > 0) begin
      check({tag, "_rx_data"}, 32'(d), 32'(e.data));
      check({tag, "_frame_err"}, 32'(fe), 32'(e.fe));
      check({tag, "_parity_err"}, 32'(pe), 32'(e.pe));
    end
  endtask

  // Scoreboard monitors: pop on every accepted rx handshake.
  always @(negedge clk) begin
    if (rst_n && rx_valid_n && rx_ready_n) begin
      int have; exp_t e;
      have = q_n.size(); e = '{8'h00, 1'b0, 1'b0};
      if (have > 0) e = q_n.pop_front();
      cmp_frame("n", have, e, rx_data_n, fe_n, pe_n);
      rx_cnt_n++;
    end
    if (rst_n && rx_valid_e && rx_ready_e) begin
      int have; exp_t e;
      have = q_e.size(); e = '{8'h00, 1'b0, 1'b0};
      if (have > 0) e = q_e.pop_front();
      cmp_frame("e", have, e, rx_data_e, fe_e, pe_e);
      rx_cnt_e++;
    end
    if (rst_n && rx_valid_o && rx_ready_o) begin
      int have; exp_t e;
      have = q_o.size(); e = '{8'h00, 1'b0, 1'b0};
      if (have > 0) e = q_o.pop_front();
      cmp_frame("o", have, e, rx_data_o, fe_o, pe_o);
      rx_cnt_o++;
    end
    if (ovr_n) ovr_cyc_n++;
    if (ovr_e) ovr_cyc_e++;
    if (ovr_o) ovr_cyc_o++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int which, input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.data = d; e.fe = fe; e.pe = pe;
    if (which == 0) begin q_n.push_back(e); push_n++; end
    else if (which == 1) begin q_e.push_back(e); push_e++; end
    else begin q_o.push_back(e); push_o++; end
  endtask

  function automatic int pending(input int which);
    if (which == 0) return q_n.size();
    if (which == 1) return q_e.size();
    return q_o.size();
  endfunction

  task automatic wait_drained(input string tag, input int which, input int budget);
    int t = 0;
    while (pending(which) > 0 && t < budget) begin
      wait_clks(1);
      t++;
    end
    check(tag, 32'(pending(which)), 32'd0);
  endtask

  task automatic set_rx(input int which, input logic b);
    if (which == 2) rx_o = b;
    else rx_n = b;
  endtask

  // par_mode: 0 none, 1 odd, 2 even; par_flip inverts the correct parity bit.
  task automatic drive_rx(input int which, input logic [7:0] d, input int par_mode,
                          input logic par_flip, input logic stop_val);
    logic p;
    set_rx(which, 1'b0);
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      set_rx(which, d[i]);
      wait_clks(BIT_CLKS);
    end
    if (par_mode != 0) begin
      p = (par_mode == 1) ? ~(^d) : ^d;
      set_rx(which, p ^ par_flip);
      wait_clks(BIT_CLKS);
    end
    set_rx(which, stop_val);
    wait_clks(BIT_CLKS);
  endtask

  // Send one byte through the 8E1 loopback and check its parity bit on the line.
  task automatic send_e(input logic [7:0] d);
    int t = 0;
    tx_data_e  = d;
    tx_valid_e = 1'b1;
    while (!tx_ready_e && t < 2000) begin
      wait_clks(1);
      t++;
    end
    check("e_tx_ready_wait", 32'(tx_ready_e), 32'd1);
    @(posedge clk); #1;
    tx_valid_e = 1'b0;
    tx_data_e  = 8'hFF;
    push(1, d, 1'b0, 1'b0);
    wait_clks(9 * BIT_CLKS + BIT_CLKS / 2);
    check($sformatf("e_parity_bit_%02h", d), 32'(tx_e), 32'(^d));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [9:0] fb;
    int cnt0, ovr0;

    // Reset state
    wait_clks(3);
    check("rst_tx", 32'(tx_n), 32'd1);
    check("rst_tx_ready", 32'(tx_ready_n), 32'd1);
    check("rst_rx_valid", 32'(rx_valid_n), 32'd0);
    check("rst_rx_data", 32'(rx_data_n), 32'd0);
    check("rst_flags", 32'({fe_n, pe_n, ovr_n}), 32'd0);
    rst_n = 1'b1;
    wait_clks(2);

    // 8N1 transmit waveform for 0x41; tx_data change after accept must be ignored
    d  = 8'h41;
    fb = {1'b1, d, 1'b0};
    tx_data_n  = d;
    tx_valid_n = 1'b1;
    @(posedge clk); #1;
    tx_valid_n = 1'b0;
    tx_data_n  = 8'hFF;
    for (int c = 0; c <= 10 * BIT_CLKS; c++) begin
      @(negedge clk);
      if (c % BIT_CLKS == 0 || c % BIT_CLKS == BIT_CLKS - 1) begin
        if (c < 10 * BIT_CLKS)
          check($sformatf("tx41_bit%0d_clk%0d", c / BIT_CLKS, c), 32'(tx_n), 32'(fb[c / BIT_CLKS]));
        check($sformatf("tx41_ready_clk%0d", c), 32'(tx_ready_n), 32'(c == 10 * BIT_CLKS));
      end
    end
    wait_clks(4);

    // 8E1 loopback
    send_e(8'h5A);
    send_e(8'h00);
    wait_drained("e_drain", 1, 2000);

    // Frame error with line held low afterwards (break)
    cnt0 = rx_cnt_n;
    push(0, 8'h3C, 1'b1, 1'b0);
    drive_rx(0, 8'h3C, 0, 1'b0, 1'b0);
    wait_clks(200);
    check("break_single_frame", 32'(rx_cnt_n), 32'(cnt0 + 1));
    set_rx(0, 1'b1);
    wait_clks(100);
    push(0, 8'h96, 1'b0, 1'b0);
    drive_rx(0, 8'h96, 0, 1'b0, 1'b1);
    wait_drained("n_drain_after_break", 0, 500);

    // 8O1 parity error then a clean frame
    push(2, 8'h01, 1'b0, 1'b1);
    drive_rx(2, 8'h01, 1, 1'b1, 1'b1);
    wait_clks(16);
    push(2, 8'h01, 1'b0, 1'b0);
    drive_rx(2, 8'h01, 1, 1'b0, 1'b1);
    wait_drained("o_drain", 2, 500);

    // Overrun with rx_ready low
    rx_ready_n = 1'b0;
    ovr0 = ovr_cyc_n;
    push(0, 8'h11, 1'b0, 1'b0);
    drive_rx(0, 8'h11, 0, 1'b0, 1'b1);
    wait_clks(16);
    drive_rx(0, 8'h22, 0, 1'b0, 1'b1);
    wait_clks(8);
    check("ovr_pulse_clks", 32'(ovr_cyc_n - ovr0), 32'd1);
    check("ovr_hold_valid", 32'(rx_valid_n), 32'd1);
    check("ovr_hold_data", 32'(rx_data_n), 32'h11);
    rx_ready_n = 1'b1;
    wait_clks(1);
    check("ovr_valid_cleared", 32'(rx_valid_n), 32'd0);
    check("ovr_queue_empty", 32'(pending(0)), 32'd0);

    // Short glitch must be rejected as a false start
    cnt0 = rx_cnt_n;
    set_rx(0, 1'b0);
    wait_clks(3 * DIV);
    set_rx(0, 1'b1);
    wait_clks(300);
    check("glitch_no_frame", 32'(rx_cnt_n), 32'(cnt0));
    push(0, 8'hC3, 1'b0, 1'b0);
    drive_rx(0, 8'hC3, 0, 1'b0, 1'b1);
    wait_drained("n_drain_after_glitch", 0, 500);

    // Asynchronous reset in the middle of a transmitted frame
    tx_data_n  = 8'hA5;
    tx_valid_n = 1'b1;
    @(posedge clk); #1;
    tx_valid_n = 1'b0;
    wait_clks(2 * BIT_CLKS + 22);
    check("rst_mid_tx_low", 32'(tx_n), 32'd0);
    #3 rst_n = 1'b0;
    #1 check("rst_mid_tx_async_high", 32'(tx_n), 32'd1);
    wait_clks(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_tx_ready", 32'(tx_ready_n), 32'd1);
    check("rst_mid_tx_line", 32'(tx_n), 32'd1);
    check("rst_mid_rx_valid", 32'(rx_valid_n), 32'd0);
    wait_clks(4);

    // Final scoreboard accounting
    check("n_frames_received", 32'(rx_cnt_n), 32'(push_n));
    check("e_frames_received", 32'(rx_cnt_e), 32'(push_e));
    check("o_frames_received", 32'(rx_cnt_o), 32'(push_o));
    check("eo_no_overrun", 32'(ovr_cyc_e + ovr_cyc_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
